// File: rtl/aes_pkg.sv
// Shared types and defaults for the serial AES core host sequencer.
// Also carries the FIPS-197 appendix C.1 vector used to exercise the path end to end.
package aes_pkg;

    localparam int W_DEF         = 128;
    localparam int FRAME_LEN_DEF = 129;
    localparam int CORE_LAT_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        KEY,
        WAIT,
        RESP
    } state_t;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// One chip-select frame: W MSB-first shift cycles, then turnaround cycles with mosi low.
// The returned miso bits replace the outgoing word, so echo holds the captured frame at the end.
module spi_frame_shifter #(
    parameter int W         = 128,
    parameter int FRAME_LEN = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         miso_in,
    output logic         mosi,
    output logic [W-1:0] echo,
    output logic         last
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            echo <= '0;
            cnt  <= '0;
            mosi <= 1'b0;
        end else if (load) begin
            echo <= load_val;
            cnt  <= '0;
            mosi <= load_val[W-1];
        end else if (shift) begin
            if (!last)
                cnt <= cnt + CW'(1);
            // The next outgoing bit sits one below the MSB before this shift lands.
            if (cnt < CW'(W)) begin
                echo <= {echo[W-2:0], miso_in};
                mosi <= (cnt == CW'(W - 1)) ? 1'b0 : echo[W-2];
            end else begin
                mosi <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_spi_sequencer.sv
// Host-side sequencer for the serial AES core: data frame, key frame, fixed core wait,
// then holds the parallel results and serial echoes until the consumer takes them.
module aes_spi_sequencer
    import aes_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CORE_LAT  = CORE_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_data,
    input  logic [W-1:0] req_key,
    output logic         cs1,
    output logic         cs2,
    output logic         mosi,
    input  logic         misod,
    input  logic         misok,
    input  logic [W-1:0] encrypted,
    input  logic [W-1:0] decrypted,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_enc,
    output logic [W-1:0] rsp_dec,
    output logic [W-1:0] rsp_echo_d,
    output logic [W-1:0] rsp_echo_k,
    output logic         busy
);

    localparam int CW = $clog2(max2(FRAME_LEN, CORE_LAT) + 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  key_q, echo_d_q, sh_echo, load_val;
    logic          load, shift, miso, sh_last, accept, wait_last;

    assign accept    = (state == IDLE) && req_valid;
    assign wait_last = (state == WAIT) && (cnt == CW'(CORE_LAT - 1));

    spi_frame_shifter #(.W(W), .FRAME_LEN(FRAME_LEN)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .shift    (shift),
        .miso_in  (miso),
        .mosi     (mosi),
        .echo     (sh_echo),
        .last     (sh_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req_valid) nxt = DATA;
            DATA:    if (sh_last)   nxt = KEY;
            KEY:     if (sh_last)   nxt = WAIT;
            WAIT:    if (wait_last) nxt = RESP;
            RESP:    if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        cs1       = 1'b1;
        cs2       = 1'b1;
        rsp_valid = 1'b0;
        load      = 1'b0;
        load_val  = req_data;
        shift     = 1'b0;
        miso      = misok;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                load      = req_valid;
            end
            DATA: begin
                cs1   = 1'b0;
                shift = 1'b1;
                miso  = misod;
                // Key frame follows on the very next cycle, so reload the shifter here.
                if (sh_last) begin
                    load     = 1'b1;
                    load_val = key_q;
                end
            end
            KEY: begin
                cs2   = 1'b0;
                shift = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            key_q      <= '0;
            echo_d_q   <= '0;
            rsp_enc    <= '0;
            rsp_dec    <= '0;
            rsp_echo_d <= '0;
            rsp_echo_k <= '0;
        end else begin
            if (accept)
                key_q <= req_key;
            if (state == DATA && sh_last)
                echo_d_q <= sh_echo;
            if (state == KEY && sh_last)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + CW'(1);
            if (wait_last) begin
                rsp_enc    <= encrypted;
                rsp_dec    <= decrypted;
                rsp_echo_d <= echo_d_q;
                rsp_echo_k <= sh_echo;
            end
        end
    end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Bench for aes_spi_sequencer: stub serial core plus a timeline model checked every cycle,
// and directed requests with literal expectations.
module tb_aes_spi_sequencer;
    import aes_pkg::*;

    localparam int W   = 128;
    localparam int FL  = 129;
    localparam int CL  = 16;
    localparam int LAT = 2 * FL + CL;

    logic         clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
    logic [W-1:0] req_data = '0, req_key = '0;
    logic         req_ready, cs1, cs2, mosi, misod, misok, rsp_valid, busy;
    logic [W-1:0] encrypted, decrypted, rsp_enc, rsp_dec, rsp_echo_d, rsp_echo_k;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    aes_spi_sequencer #(.W(W), .FRAME_LEN(FL), .CORE_LAT(CL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_key    (req_key),
        .cs1        (cs1),
        .cs2        (cs2),
        .mosi       (mosi),
        .misod      (misod),
        .misok      (misok),
        .encrypted  (encrypted),
        .decrypted  (decrypted),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_enc    (rsp_enc),
        .rsp_dec    (rsp_dec),
        .rsp_echo_d (rsp_echo_d),
        .rsp_echo_k (rsp_echo_k),
        .busy       (busy)
    );

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stand-in core: the real cipher for the FIPS pair, a cheap mix otherwise.
    function automatic logic [W-1:0] core_fn(input logic [W-1:0] d, input logic [W-1:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ {k[63:0], k[127:64]};
    endfunction

    // Stub serial core: records mosi per frame and plays back a pattern on miso.
    logic [W-1:0] pat_d = '0, pat_k = '0, cap_d = '0, cap_k = '0;
    int kd = 0, kk = 0;

    always @(posedge clk) begin
        if (cs1 === 1'b0) begin
            if (kd < W) cap_d <= {cap_d[W-2:0], mosi};
            kd <= kd + 1;
        end else kd <= 0;
        if (cs2 === 1'b0) begin
            if (kk < W) cap_k <= {cap_k[W-2:0], mosi};
            kk <= kk + 1;
        end else kk <= 0;
    end

    assign misod     = (kd < W) ? pat_d[W-1-kd] : 1'b0;
    assign misok     = (kk < W) ? pat_k[W-1-kk] : 1'b0;
    assign encrypted = core_fn(cap_d, cap_k);
    assign decrypted = cap_d;

    // Timeline model: t counts cycles since the accept edge.
    logic         m_act = 1'b0;
    int           t = 0;
    logic [W-1:0] e_d = '0, e_k = '0, e_pd = '0, e_pk = '0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) m_act <= 1'b0;
        else if (!m_act && req_valid) begin
            m_act <= 1'b1;
            t     <= 0;
            e_d   <= req_data;
            e_k   <= req_key;
            e_pd  <= pat_d;
            e_pk  <= pat_k;
        end else if (m_act && t >= LAT && rsp_ready) m_act <= 1'b0;
        else if (m_act) t <= t + 1;
    end

    logic x_cs1, x_cs2, x_mosi, x_rv;

    always @(negedge clk) begin
        if (chk_en) begin
            x_cs1  = !(m_act && t < FL);
            x_cs2  = !(m_act && t >= FL && t < 2 * FL);
            x_rv   = m_act && t >= LAT;
            if (m_act && t < W)                    x_mosi = e_d[W-1-t];
            else if (m_act && t >= FL && t < FL+W) x_mosi = e_k[W-1-(t-FL)];
            else                                   x_mosi = 1'b0;
            chkb("cs1", cs1, x_cs1);
            chkb("cs2", cs2, x_cs2);
            chkb("cs_never_both_low", cs1 | cs2, 1'b1);
            chkb("mosi", mosi, x_mosi);
            chkb("req_ready", req_ready, !m_act);
            chkb("busy", busy, m_act);
            chkb("rsp_valid", rsp_valid, x_rv);
            if (x_rv) begin
                chkw("rsp_enc", rsp_enc, core_fn(e_d, e_k));
                chkw("rsp_dec", rsp_dec, e_d);
                chkw("rsp_echo_d", rsp_echo_d, e_pd);
                chkw("rsp_echo_k", rsp_echo_k, e_pk);
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] k,
                        input logic [W-1:0] pd, input logic [W-1:0] pk);
        pat_d = pd;
        pat_k = pk;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = d;
        req_key   = k;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [W-1:0] d, input logic [W-1:0] k,
                           input logic [W-1:0] pd, input logic [W-1:0] pk);
        int n, lo1, lo2;
        send(d, k, pd, pk);
        n = 0; lo1 = 0; lo2 = 0;
        @(negedge clk);
        while (!rsp_valid && n < 400) begin
            if (!cs1) lo1++;
            if (!cs2) lo2++;
            n++;
            @(negedge clk);
        end
        chki("rsp_latency", n, LAT);
        chki("cs1_low_cycles", lo1, FL);
        chki("cs2_low_cycles", lo2, FL);
        chkw("mosi_data_stream", cap_d, d);
        chkw("mosi_key_stream", cap_k, k);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chkb("req_ready_after_release", req_ready, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // idle after reset
        repeat (10) @(negedge clk);
        chkb("rst_req_ready", req_ready, 1'b1);
        chkb("rst_cs1", cs1, 1'b1);
        chkw("rst_rsp_enc", rsp_enc, '0);
        chkw("rst_rsp_echo_k", rsp_echo_k, '0);

        // FIPS-197 vector, frame timing and mosi stream
        run_req(FIPS_PT, FIPS_KEY, 128'h0123456789abcdef_fedcba9876543210, 128'h5a5a_0000_ffff_1234_a5a5_c3c3_0f0f_8001);
        chkw("fips_enc", rsp_enc, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chkw("fips_dec", rsp_dec, 128'h00112233445566778899aabbccddeeff);
        chkw("fips_echo_d", rsp_echo_d, 128'h0123456789abcdef_fedcba9876543210);
        release_rsp();

        // misod tied high, misok tied low
        run_req(128'hffffffff_ffffffff_00000000_00000000, 128'h00000000_00000001_00000000_00000000, '1, '0);
        chkw("stub_enc", rsp_enc, 128'hffffffff_ffffffff_00000000_00000001);
        chkw("echo_d_ones", rsp_echo_d, {W{1'b1}});
        chkw("echo_k_zero", rsp_echo_k, '0);
        release_rsp();

        // consumer back-pressure with stray requests
        run_req(FIPS_PT, FIPS_KEY, 128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        for (int i = 0; i < 50; i++) begin
            req_valid = (i % 10 == 3);
            req_data  = 128'hdead;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chkb("held_rsp_valid", rsp_valid, 1'b1);
        chkw("held_enc", rsp_enc, FIPS_CT);
        chkw("held_echo_k", rsp_echo_k, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        release_rsp();
        run_req(128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f, 128'h0, 128'h3, 128'hc);
        chkw("second_enc", rsp_enc, 128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f);
        release_rsp();

        // reset mid data frame, then a fresh request
        send(FIPS_PT, FIPS_KEY, '1, '1);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chkb("midrst_cs1", cs1, 1'b1);
        chkb("midrst_cs2", cs2, 1'b1);
        chkb("midrst_busy", busy, 1'b0);
        run_req(FIPS_PT, FIPS_KEY, 128'h77, 128'h99);
        chkw("post_rst_enc", rsp_enc, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        release_rsp();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
